spike_pattern_decoder: RTL and testbench
========================================

SPIKE_PATTERN_DECODER -- requirements
Module: spike_pattern_decoder

Interface
REQ-001 SHALL have parameter N, default 7: number of spike inputs; indices 0-3 are pattern neurons and index 6 is the inhibitory neuron.
REQ-002 SHALL have parameter WINDOW, default 1000: the length of the counting window in clock cycles; legal range is 2 to 65535.
REQ-003 SHALL have parameter THRESHOLD, default 4: the minimum spike count for a pattern bit to be read as 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, which is synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: request to open a counting window.
REQ-007 SHALL have port spikes, input, N bits: spike outputs of the Hopfield network, one bit per neuron.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-011 SHALL have port pattern_out, output, 4 bits: the recalled pattern, bit i for neuron i.
REQ-012 SHALL have port inhib_count, output, 8 bits: the spike count of neuron 6.
REQ-013 SHALL have port winner, output, 2 bits: the index of the neuron in 0-3 with the highest count.
REQ-014 SHALL have port sat_flag, output, 1 bit: high if any counter saturated during the window.

Function
REQ-015 SHALL implement states IDLE, COUNT and DONE.
REQ-016 SHALL register spikes into prev_spikes on every cycle, in every state, and define an edge on neuron n as spikes[n] high while prev_spikes[n] is low.
REQ-017 SHALL count edges only; a level held high counts once, and a level already high when the window opens counts zero.
REQ-018 SHALL keep one 8-bit counter per neuron; each counter saturates at 255, and an edge arriving at 255 sets a sticky saturation bit for that window.
REQ-019 SHALL, when start is high in IDLE at cycle T, clear all counters, the window counter and the saturation bit, and enter COUNT at T+1.
REQ-020 SHALL count edges during COUNT for exactly WINDOW cycles, T+1 through T+WINDOW inclusive; the 16-bit window counter ends at WINDOW-1.
REQ-021 SHALL, on the last COUNT cycle, load the outputs from the final counts, including an edge arriving on that cycle, and enter DONE with out_valid high from T+WINDOW+1.
REQ-022 SHALL set pattern_out[i] to 1 exactly when count[i] is greater than or equal to THRESHOLD (unsigned compare).
REQ-023 SHALL set winner to the index of the maximum of counts 0-3; ties resolve to the lowest index, and all-zero counts give 0.
REQ-024 SHALL hold out_valid, pattern_out, inhib_count, winner and sat_flag stable in DONE until the cycle where out_valid and out_ready are both high.
REQ-025 SHALL, on a handshake in DONE with start low, go to IDLE with out_valid low on the next cycle; the data outputs keep their last values.
REQ-026 SHALL, on a handshake in DONE with start high, go directly to COUNT with out_valid low and busy high on the next cycle, clearing counters as in REQ-019.
REQ-027 SHALL ignore start in COUNT, and in DONE when there is no handshake.
REQ-028 SHALL ignore out_ready when out_valid is low.
REQ-029 SHALL tolerate spike bits 4-5; they are counted internally but do not drive any output.

Reset
REQ-030 SHALL, when reset_n is low at a clock edge, set the state to IDLE, and set busy, out_valid, pattern_out, inhib_count, winner, sat_flag, all counters, the window counter and prev_spikes to 0, regardless of the other inputs.
REQ-031 SHALL, on reset during COUNT or DONE, discard the window silently; out_valid is 0 after the edge and no result is produced.

Verification (bench parameters: WINDOW=16, THRESHOLD=3 unless stated)
REQ-032 SHALL cover reset: reset_n low for 2 cycles with spikes=7'h7F and start=1 -> busy=0, out_valid=0, pattern_out=0, inhib_count=0, winner=0, sat_flag=0.
REQ-033 SHALL cover basic decode: start at T; within the window give neuron 0 four single-cycle pulses, neuron 2 two pulses and neuron 6 five pulses -> out_valid rises at T+17, pattern_out=4'b0001, winner=0, inhib_count=5, sat_flag=0.
REQ-034 SHALL cover edge semantics: spikes[1] held high from before start through the window, and spikes[3] rising once and then held -> count[1]=0, count[3]=1, pattern_out=0, winner=3.
REQ-035 SHALL cover saturation and ties: with WINDOW=600, neuron 3 toggles every cycle (300 edges) and neuron 2 has 255 edges -> counts of 255 on both, sat_flag=1, pattern_out=4'b1100, winner=2.
REQ-036 SHALL cover backpressure and back-to-back windows: out_ready low for 10 cycles after out_valid, with start pulsed -> all outputs stable and start ignored; then out_ready=1 and start=1 in the same cycle -> next cycle out_valid=0, busy=1, and a new result arrives 16 cycles later.
REQ-037 SHALL cover reset mid-window: reset_n low for 1 cycle at the 8th COUNT cycle -> next cycle state IDLE, busy=0, and out_valid never asserts for that window.

Source files
------------

// File: rtl/spike_pattern_decoder.sv
// spike_pattern_decoder
// Counts rising edges per spike line over a fixed window, then reports
// the recalled 4-bit pattern, the inhibitory neuron count, the strongest
// pattern neuron and whether any counter saturated.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no window open, waiting for start
// COUNT | window open, counting spike edges for WINDOW cycles
// DONE  | result held on the outputs until out_valid & out_ready
module spike_pattern_decoder #(
  parameter int N         = 7,
  parameter int WINDOW    = 1000,
  parameter int THRESHOLD = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] spikes,
  input  logic         out_ready,
  output logic         busy,
  output logic         out_valid,
  output logic [3:0]   pattern_out,
  output logic [7:0]   inhib_count,
  output logic [1:0]   winner,
  output logic         sat_flag
);

  localparam int          INHIB_IDX = 6;
  localparam logic [15:0] WIN_LAST  = 16'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [N-1:0] r_prev_spikes;
  logic [7:0]  r_cnt [N];
  logic [15:0] r_win;
  logic        r_sat;

  logic        r_busy;
  logic        r_out_valid;
  logic [3:0]  r_pattern;
  logic [7:0]  r_inhib;
  logic [1:0]  r_winner;
  logic        r_sat_flag;

  logic [N-1:0] w_edge;
  logic [7:0]   w_cnt_next [N];
  logic         w_sat_next;
  logic         w_handshake;
  logic         w_open;
  logic         w_last;
  logic [3:0]   w_pattern;
  logic [1:0]   w_winner;
  logic [7:0]   w_best;

  // out_valid is only ever high in DONE, so this is the DONE handshake
  assign w_handshake = r_out_valid & out_ready;
  // a new window opens from IDLE on start, or straight out of DONE when
  // the consumer takes the result in the same cycle start is raised
  assign w_open = start & ((r_state == IDLE) | ((r_state == DONE) & w_handshake));
  assign w_last = (r_state == COUNT) && (r_win == WIN_LAST);

  // Edge detect and saturating next-count; edges only matter while counting
  always_comb begin
    w_edge     = spikes & ~r_prev_spikes;
    w_sat_next = r_sat;
    for (int i = 0; i < N; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if ((r_state == COUNT) && w_edge[i]) begin
        if (r_cnt[i] == 8'hFF) begin
          w_sat_next = 1'b1;
        end else begin
          w_cnt_next[i] = r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Decode from next-counts so an edge on the final window cycle is included
  always_comb begin
    w_pattern = 4'b0000;
    w_winner  = 2'd0;
    w_best    = w_cnt_next[0];
    for (int i = 0; i < 4; i++) begin
      w_pattern[i] = ({24'd0, w_cnt_next[i]} >= 32'(THRESHOLD));
    end
    // strict greater-than keeps the lowest index on ties
    for (int i = 1; i < 4; i++) begin
      if (w_cnt_next[i] > w_best) begin
        w_best   = w_cnt_next[i];
        w_winner = 2'(i);
      end
    end
  end

  // Previous-spike register runs in every state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev_spikes <= '0;
    end else begin
      r_prev_spikes <= spikes;
    end
  end

  // Per-neuron edge counters and sticky saturation bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= 8'd0;
      end
      r_sat <= 1'b0;
    end else if (w_open) begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= 8'd0;
      end
      r_sat <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      r_sat <= w_sat_next;
    end
  end

  // Window position: 0 on the first COUNT cycle, WINDOW-1 on the last
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_win <= 16'd0;
    end else if (w_open) begin
      r_win <= 16'd0;
    end else if ((r_state == COUNT) && !w_last) begin
      r_win <= r_win + 16'd1;
    end
  end

  // Sequencer with registered status and result outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_pattern   <= 4'b0000;
      r_inhib     <= 8'd0;
      r_winner    <= 2'd0;
      r_sat_flag  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= COUNT;
            r_busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_pattern   <= w_pattern;
            r_inhib     <= w_cnt_next[INHIB_IDX];
            r_winner    <= w_winner;
            r_sat_flag  <= w_sat_next;
          end
        end
        DONE: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (start) begin
              r_state <= COUNT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign out_valid   = r_out_valid;
  assign pattern_out = r_pattern;
  assign inhib_count = r_inhib;
  assign winner      = r_winner;
  assign sat_flag    = r_sat_flag;

endmodule

// File: tb/tb_spike_pattern_decoder.sv
// Bench for spike_pattern_decoder: WINDOW=16/THRESHOLD=3 instance for most
// scenarios and a WINDOW=600 instance for saturation. Expected results come
// from counting 0->1 transitions in the applied spike sequence.
module tb_spike_pattern_decoder;

  localparam int N  = 7;
  localparam int W  = 16;
  localparam int W2 = 600;
  localparam int TH = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, start2;
  logic         out_ready, out_ready2;
  logic [N-1:0] spikes;

  logic       busy, out_valid, sat_flag;
  logic [3:0] pattern_out;
  logic [7:0] inhib_count;
  logic [1:0] winner;

  logic       busy2, out_valid2, sat_flag2;
  logic [3:0] pattern_out2;
  logic [7:0] inhib_count2;
  logic [1:0] winner2;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] v [0:W2];
  logic [3:0]   e_pat;
  logic [7:0]   e_inh;
  logic [1:0]   e_win;
  logic         e_sat;

  always #5 clk = ~clk;

  spike_pattern_decoder #(.N(N), .WINDOW(W), .THRESHOLD(TH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .spikes(spikes),
    .out_ready(out_ready), .busy(busy), .out_valid(out_valid),
    .pattern_out(pattern_out), .inhib_count(inhib_count),
    .winner(winner), .sat_flag(sat_flag)
  );

  spike_pattern_decoder #(.N(N), .WINDOW(W2), .THRESHOLD(TH)) dut_w (
    .clk(clk), .reset_n(reset_n), .start(start2), .spikes(spikes),
    .out_ready(out_ready2), .busy(busy2), .out_valid(out_valid2),
    .pattern_out(pattern_out2), .inhib_count(inhib_count2),
    .winner(winner2), .sat_flag(sat_flag2)
  );

  // Reference: count 0->1 transitions in v[0..w], saturate, then decode
  task automatic model(input int w);
    int raw [N];
    int c, best;
    for (int n = 0; n < N; n++) begin
      raw[n] = 0;
      for (int k = 1; k <= w; k++)
        if (v[k][n] && !v[k-1][n]) raw[n]++;
    end
    e_sat = 1'b0;
    for (int n = 0; n < N; n++)
      if (raw[n] > 255) e_sat = 1'b1;
    e_win = 2'd0;
    best  = -1;
    for (int i = 0; i < 4; i++) begin
      c = (raw[i] > 255) ? 255 : raw[i];
      e_pat[i] = (c >= TH);
      if (c > best) begin
        best  = c;
        e_win = 2'(i);
      end
    end
    e_inh = 8'((raw[6] > 255) ? 255 : raw[6]);
  endtask

  task automatic fill_random(input int w);
    for (int k = 0; k <= w; k++) v[k] = 7'($urandom);
  endtask

  // Open a window (with a DONE handshake when hs=1), play v[0..w], check result
  task automatic run_window(input bit sel, input int w, input bit hs, input string name);
    logic       o_v, o_b, o_s;
    logic [3:0] o_p;
    logic [7:0] o_i;
    logic [1:0] o_w;
    @(negedge clk);
    if (sel) begin start2 = 1'b1; out_ready2 = hs; end
    else     begin start  = 1'b1; out_ready  = hs; end
    spikes = v[0];
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      o_v = sel ? out_valid2 : out_valid;
      o_b = sel ? busy2 : busy;
      tests++;
      if ({o_v, o_b} !== 2'b01) begin
        fails++;
        $display("FAIL %s window_open k=%0d: valid,busy=%b%b required 01", name, k, o_v, o_b);
      end
      spikes = v[k];
      start = 1'b0; start2 = 1'b0; out_ready = 1'b0; out_ready2 = 1'b0;
    end
    @(negedge clk);
    model(w);
    o_v = sel ? out_valid2 : out_valid;
    o_b = sel ? busy2 : busy;
    o_p = sel ? pattern_out2 : pattern_out;
    o_i = sel ? inhib_count2 : inhib_count;
    o_w = sel ? winner2 : winner;
    o_s = sel ? sat_flag2 : sat_flag;
    tests++;
    if ({o_v, o_b} !== 2'b11) begin
      fails++;
      $display("FAIL %s result_valid: valid,busy=%b%b required 11", name, o_v, o_b);
    end
    tests++;
    if (o_p !== e_pat) begin
      fails++;
      $display("FAIL %s pattern_out: got %b required %b", name, o_p, e_pat);
    end
    tests++;
    if (o_i !== e_inh) begin
      fails++;
      $display("FAIL %s inhib_count: got %0d required %0d", name, o_i, e_inh);
    end
    tests++;
    if (o_w !== e_win) begin
      fails++;
      $display("FAIL %s winner: got %0d required %0d", name, o_w, e_win);
    end
    tests++;
    if (o_s !== e_sat) begin
      fails++;
      $display("FAIL %s sat_flag: got %b required %b", name, o_s, e_sat);
    end
  endtask

  // Handshake with start low: back to IDLE, data outputs retained
  task automatic release_result(input bit sel, input string name);
    logic       o_v, o_b;
    logic [3:0] o_p;
    if (sel) out_ready2 = 1'b1; else out_ready = 1'b1;
    spikes = '0;
    @(negedge clk);
    out_ready = 1'b0; out_ready2 = 1'b0;
    o_v = sel ? out_valid2 : out_valid;
    o_b = sel ? busy2 : busy;
    o_p = sel ? pattern_out2 : pattern_out;
    tests++;
    if ({o_v, o_b, o_p} !== {2'b00, e_pat}) begin
      fails++;
      $display("FAIL %s release: valid,busy,pattern=%b%b %b required 00 %b", name, o_v, o_b, o_p, e_pat);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; start2 = 1'b1; spikes = 7'h7F;
    out_ready = 1'b1; out_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, out_valid, sat_flag} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: busy,valid,sat=%b%b%b required 000", busy, out_valid, sat_flag);
    end
    tests++;
    if (pattern_out !== 4'd0) begin
      fails++;
      $display("FAIL reset_pattern: got %b required 0000", pattern_out);
    end
    tests++;
    if (inhib_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_inhib: got %0d required 0", inhib_count);
    end
    tests++;
    if (winner !== 2'd0) begin
      fails++;
      $display("FAIL reset_winner: got %0d required 0", winner);
    end
    tests++;
    if ({busy2, out_valid2} !== 2'b00) begin
      fails++;
      $display("FAIL reset_wide: busy,valid=%b%b required 00", busy2, out_valid2);
    end
    start = 1'b0; start2 = 1'b0; spikes = '0; out_ready = 1'b0; out_ready2 = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    for (int k = 0; k <= W; k++) v[k] = '0;
    for (int k = 1; k <= 7; k += 2) v[k][0] = 1'b1;
    v[2][2] = 1'b1; v[6][2] = 1'b1;
    for (int k = 1; k <= 9; k += 2) v[k][6] = 1'b1;
    run_window(1'b0, W, 1'b0, "basic");
    release_result(1'b0, "basic");
  endtask

  task automatic test_edge_semantics();
    for (int k = 0; k <= W; k++) begin
      v[k] = '0;
      v[k][1] = 1'b1;
      if (k >= 2) v[k][3] = 1'b1;
    end
    @(negedge clk);
    spikes = 7'b0000010;
    run_window(1'b0, W, 1'b0, "edge");
    release_result(1'b0, "edge");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      fill_random(W);
      run_window(1'b0, W, 1'b0, "random");
      release_result(1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    fill_random(W);
    run_window(1'b0, W, 1'b0, "bp_first");
    for (int c = 0; c < 10; c++) begin
      out_ready = 1'b0;
      start = (c % 3 == 1);
      spikes = 7'($urandom);
      @(negedge clk);
      tests++;
      if ({out_valid, busy, pattern_out, inhib_count, winner, sat_flag} !==
          {2'b11, e_pat, e_inh, e_win, e_sat}) begin
        fails++;
        $display("FAIL backpressure_hold c=%0d: v%b b%b p%b i%0d w%0d s%b required v1 b1 p%b i%0d w%0d s%b",
                 c, out_valid, busy, pattern_out, inhib_count, winner, sat_flag,
                 e_pat, e_inh, e_win, e_sat);
      end
    end
    start = 1'b0;
    fill_random(W);
    run_window(1'b0, W, 1'b1, "bp_second");
    release_result(1'b0, "bp_second");
  endtask

  task automatic test_reset_mid_window();
    fill_random(W);
    @(negedge clk);
    start = 1'b1; spikes = v[0];
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0; spikes = v[k];
    end
    @(negedge clk);
    reset_n = 1'b0; spikes = v[8];
    @(negedge clk);
    reset_n = 1'b1;
    tests++;
    if ({busy, out_valid} !== 2'b00) begin
      fails++;
      $display("FAIL midreset_idle: busy,valid=%b%b required 00", busy, out_valid);
    end
    for (int k = 0; k < 2 * W; k++) begin
      spikes = 7'($urandom);
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL midreset_no_result k=%0d: valid=%b required 0", k, out_valid);
      end
    end
    fill_random(W);
    run_window(1'b0, W, 1'b0, "after_reset");
    release_result(1'b0, "after_reset");
  endtask

  task automatic test_saturation();
    for (int k = 0; k <= W2; k++) begin
      v[k] = '0;
      v[k][3] = k[0];
      if ((k % 2 == 0) && (k >= 2) && (k <= 510)) v[k][2] = 1'b1;
    end
    run_window(1'b1, W2, 1'b0, "saturation");
    release_result(1'b1, "saturation");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_semantics();
    test_random();
    test_back_to_back();
    test_reset_mid_window();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
